// File: rtl/f_pc_unit.sv
// Fetch-stage PC register: next-PC selection, exception/eret redirect and a
// circular return-address stack that cross-checks every jr $ra.
module f_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  D_NPCop,
  input  logic [31:0] D_PC,
  input  logic [15:0] D_imm16,
  input  logic [25:0] D_imm26,
  input  logic        D_cmp,
  input  logic [31:0] D_reg_data,
  input  logic        D_rs_is_ra,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] F_PC,
  output logic [31:0] ras_top,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_mispredict
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [CW-1:0] ras_cnt;
  logic [PW-1:0] top_idx;
  logic [31:0]   npc;
  logic          op_ok;
  logic          push_en;
  logic          pop_en;

  always_comb begin
    npc = F_PC + 32'd4;
    case (D_NPCop)
      3'd1:    if (D_cmp) npc = D_PC + 32'd4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
      3'd2,
      3'd3:    npc = {D_PC[31:28], D_imm26, 2'b00};
      3'd4,
      3'd5:    npc = D_reg_data;
      default: npc = F_PC + 32'd4;
    endcase
  end

  // Stack traffic only happens when the D-stage instruction actually retires
  // its control transfer: no stall and no exception/eret redirect.
  assign op_ok   = !stall && !exc_req && !eret_req;
  assign push_en = op_ok && (D_NPCop == 3'd3 || D_NPCop == 3'd5);
  assign pop_en  = op_ok && (D_NPCop == 3'd4) && D_rs_is_ra;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_MAX);
  assign top_idx   = ras_ptr - PW'(1);
  assign ras_top   = ras_empty ? 32'd0 : ras_mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC           <= RESET_PC;
      ras_ptr        <= '0;
      ras_cnt        <= '0;
      ras_mispredict <= 1'b0;
    end else begin
      if (exc_req)       F_PC <= EXC_VECTOR;
      else if (eret_req) F_PC <= epc;
      else if (!stall)   F_PC <= npc;

      ras_mispredict <= pop_en && (ras_empty || (D_reg_data != ras_top));

      // A push onto a full stack silently overwrites the oldest entry.
      if (push_en) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (!ras_full) ras_cnt <= ras_cnt + CW'(1);
      end else if (pop_en && !ras_empty) begin
        ras_ptr <= ras_ptr - PW'(1);
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_en) ras_mem[ras_ptr] <= D_PC + 32'd8;
  end

endmodule

// File: tb/tb_f_pc_unit.sv
// Bench for f_pc_unit: directed vector table from the bring-up sequence,
// then randomized traffic against a queue-based reference model.
module tb_f_pc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, D_cmp, D_rs_is_ra, exc_req, eret_req;
  logic [2:0]  D_NPCop;
  logic [31:0] D_PC, D_reg_data, epc;
  logic [15:0] D_imm16;
  logic [25:0] D_imm26;
  logic [31:0] F_PC, ras_top;
  logic        ras_empty, ras_full, ras_mispredict;

  f_pc_unit #(.RESET_PC(32'h0000_3000), .EXC_VECTOR(32'h0000_4180), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .D_NPCop(D_NPCop), .D_PC(D_PC),
    .D_imm16(D_imm16), .D_imm26(D_imm26), .D_cmp(D_cmp), .D_reg_data(D_reg_data),
    .D_rs_is_ra(D_rs_is_ra), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .F_PC(F_PC), .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: architectural PC, stack as a bounded queue (back = top)
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis;

  typedef struct {
    logic [3:0]  ctl;    // {reset, stall, exc, eret}
    logic [2:0]  op;
    logic [31:0] dpc;
    logic [31:0] imm;    // low 16 bits for branches, low 26 for jumps
    logic        cmp;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic [31:0] e_top;
    logic [2:0]  e_flags; // {empty, full, mispredict}
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic [31:0] ctl, op, dpc, imm, cmp, rdata, ep,
                              e_pc, e_top, e_flags);
    vec_t v;
    v.ctl = ctl[3:0]; v.op = op[2:0]; v.dpc = dpc; v.imm = imm; v.cmp = cmp[0];
    v.rdata = rdata; v.epc = ep; v.e_pc = e_pc; v.e_top = e_top; v.e_flags = e_flags[2:0];
    return v;
  endfunction

  function automatic logic [31:0] m_top();
    return (m_ras.size() == 0) ? 32'd0 : m_ras[m_ras.size()-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance the model using the inputs currently on the pins.
  task automatic model_step();
    logic [31:0] nxt;
    logic        ok;
    if (reset) begin
      m_pc = 32'h3000; m_ras.delete(); m_mis = 1'b0;
      return;
    end
    case (D_NPCop)
      3'd1:    nxt = D_cmp ? D_PC + 32'd4 + 32'(signed'(D_imm16)) * 32'd4 : m_pc + 32'd4;
      3'd2,
      3'd3:    nxt = (D_PC & 32'hF000_0000) | (32'(D_imm26) * 32'd4);
      3'd4,
      3'd5:    nxt = D_reg_data;
      default: nxt = m_pc + 32'd4;
    endcase
    ok = !stall && !exc_req && !eret_req;
    m_mis = 1'b0;
    if (ok && D_NPCop == 3'd4 && D_rs_is_ra) begin
      m_mis = (m_ras.size() == 0) || (D_reg_data != m_top());
      if (m_ras.size() > 0) void'(m_ras.pop_back());
    end
    if (ok && (D_NPCop == 3'd3 || D_NPCop == 3'd5)) begin
      m_ras.push_back(D_PC + 32'd8);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
    if (exc_req)       m_pc = 32'h4180;
    else if (eret_req) m_pc = epc;
    else if (!stall)   m_pc = nxt;
  endtask

  task automatic tick_check(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".pc"},    F_PC, m_pc);
    chk({tag, ".top"},   ras_top, m_top());
    chk({tag, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
    chk({tag, ".full"},  32'(ras_full), 32'(m_ras.size() == DEPTH));
    chk({tag, ".mis"},   32'(ras_mispredict), 32'(m_mis));
  endtask

  task automatic apply(input vec_t v);
    {reset, stall, exc_req, eret_req} = v.ctl;
    D_NPCop = v.op; D_PC = v.dpc; D_imm16 = v.imm[15:0]; D_imm26 = v.imm[25:0];
    D_cmp = v.cmp; D_reg_data = v.rdata; D_rs_is_ra = 1'b1; epc = v.epc;
  endtask

  initial begin
    m_pc = 32'h0; m_mis = 1'b0;
    {reset, stall, exc_req, eret_req, D_cmp, D_rs_is_ra} = '0;
    D_NPCop = '0; D_PC = '0; D_imm16 = '0; D_imm26 = '0; D_reg_data = '0; epc = '0;

    //               ctl  op dpc     imm     cmp rdata   epc     e_pc    e_top  {E,F,M}
    vecs[0]  = mk('b1000, 0, 0,      0,      0, 0,      0,      'h3000, 0,      'b100);
    vecs[1]  = mk(0,      0, 0,      0,      0, 0,      0,      'h3004, 0,      'b100);
    vecs[2]  = mk(0,      0, 0,      0,      0, 0,      0,      'h3008, 0,      'b100);
    vecs[3]  = mk(0,      0, 0,      0,      0, 0,      0,      'h300C, 0,      'b100);
    vecs[4]  = mk(0,      1, 'h3010, 'hFFFC, 1, 0,      0,      'h3004, 0,      'b100);
    vecs[5]  = mk(0,      1, 'h3010, 'hFFFC, 0, 0,      0,      'h3008, 0,      'b100);
    vecs[6]  = mk(0,      3, 'h3020, 'hD00,  0, 0,      0,      'h3400, 'h3028, 'b000);
    vecs[7]  = mk(0,      4, 'h3400, 0,      0, 'h3028, 0,      'h3028, 0,      'b100);
    vecs[8]  = mk(0,      3, 'h3000, 'hC00,  0, 0,      0,      'h3000, 'h3008, 'b000);
    vecs[9]  = mk(0,      3, 'h3100, 'hC00,  0, 0,      0,      'h3000, 'h3108, 'b000);
    vecs[10] = mk(0,      3, 'h3200, 'hC00,  0, 0,      0,      'h3000, 'h3208, 'b000);
    vecs[11] = mk(0,      3, 'h3300, 'hC00,  0, 0,      0,      'h3000, 'h3308, 'b010);
    vecs[12] = mk(0,      3, 'h3400, 'hC00,  0, 0,      0,      'h3000, 'h3408, 'b010);
    vecs[13] = mk(0,      4, 'h3000, 0,      0, 'h3408, 0,      'h3408, 'h3308, 'b000);
    vecs[14] = mk(0,      4, 'h3000, 0,      0, 'h3308, 0,      'h3308, 'h3208, 'b000);
    vecs[15] = mk(0,      4, 'h3000, 0,      0, 'h3208, 0,      'h3208, 'h3108, 'b000);
    vecs[16] = mk(0,      4, 'h3000, 0,      0, 'h3108, 0,      'h3108, 0,      'b100);
    vecs[17] = mk(0,      4, 'h3000, 0,      0, 'h3008, 0,      'h3008, 0,      'b101);
    vecs[18] = mk(0,      0, 0,      0,      0, 0,      0,      'h300C, 0,      'b100);
    vecs[19] = mk('b0100, 3, 'h3020, 'hD00,  0, 0,      0,      'h300C, 0,      'b100);
    vecs[20] = mk('b0110, 3, 'h3020, 'hD00,  0, 0,      0,      'h4180, 0,      'b100);
    vecs[21] = mk('b0001, 0, 0,      0,      0, 0,      'h3044, 'h3044, 0,      'b100);
    vecs[22] = mk(0,      3, 'h3020, 'hD00,  0, 0,      0,      'h3400, 'h3028, 'b000);
    vecs[23] = mk('b1010, 3, 'h3020, 'hD00,  0, 0,      0,      'h3000, 0,      'b100);
    vecs[24] = mk('b0011, 0, 0,      0,      0, 0,      'h3044, 'h4180, 0,      'b100);
    vecs[25] = mk(0,      0, 0,      0,      0, 0,      0,      'h4184, 0,      'b100);

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      tick_check($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.pc_exp", i), F_PC, vecs[i].e_pc);
      chk($sformatf("vec%0d.top_exp", i), ras_top, vecs[i].e_top);
      chk($sformatf("vec%0d.flags_exp", i), 32'({ras_empty, ras_full, ras_mispredict}),
          32'(vecs[i].e_flags));
    end

    // mispredict lasts exactly one cycle even while stalled afterwards
    {reset, stall, exc_req, eret_req} = 4'b0000;
    D_NPCop = 3'd4; D_rs_is_ra = 1'b1; D_reg_data = 32'h1234;
    tick_check("mis_pulse");
    chk("mis_pulse.high", 32'(ras_mispredict), 32'd1);
    stall = 1'b1;
    tick_check("mis_drop");
    chk("mis_drop.low", 32'(ras_mispredict), 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      stall      = ($urandom_range(0, 4) == 0);
      exc_req    = ($urandom_range(0, 19) == 0);
      eret_req   = ($urandom_range(0, 19) == 0);
      D_NPCop    = 3'($urandom_range(0, 7));
      D_PC       = $urandom;
      D_imm16    = 16'($urandom);
      D_imm26    = 26'($urandom);
      D_cmp      = 1'($urandom);
      D_rs_is_ra = ($urandom_range(0, 4) != 0);
      D_reg_data = ($urandom_range(0, 1) == 0) ? m_top() : $urandom;
      epc        = $urandom;
      tick_check($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
